instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Builds 18-bit instruction words in the switch-bank format that the control-unit decoder consumes. Requests arrive as discrete fields with a signed 16-bit immediate. Each request is validated and packed; immediates are converted to sign-magnitude form. Packed words are buffered in a small FIFO and issued to the decoder side over a valid/ready handshake. This block lets a sequencer or test host drive the CPU in place of the physical switches.

Parameters:
FIFO_DEPTH, 4, number of buffered instruction words (power of two, >= 2)
IMM_MAX, 63, largest encodable immediate magnitude (6-bit field)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request fields valid this cycle
req_ready  output  1  encoder can accept a request this cycle
req_op  input  3  opcode: 000 LOAD, 001 ADD, 010 ADDI, 011 SUB, 100 SUBI, 101 MUL, 110 CLEAR, 111 reserved
req_dest  input  4  destination register
req_src1  input  4  first source register
req_src2  input  4  second source register (register-register ops only)
req_imm  input  16  two's-complement immediate (LOAD/ADDI/SUBI only)
out_valid  output  1  out_word holds a valid instruction
out_ready  input  1  consumer takes out_word this cycle
out_word  output  18  packed instruction: [17:15] op, [14:11] dest, [10:7] src1, [6:0] operand field
err_pulse  output  1  one-cycle pulse: accepted request was rejected
err_code  output  2  00 none, 01 immediate out of range, 10 reserved opcode (held until next error or reset)
err_count  output  8  saturating count of rejected requests
fifo_level  output  3  current number of buffered words (0..FIFO_DEPTH)

Behaviour:
- Reset, rst_n low at a clock edge: FIFO emptied; out_valid=0, out_word=0, err_pulse=0, err_code=00, err_count=0, fifo_level=0. This takes priority over every other event, including a handshake in the same cycle.
- A request is accepted when req_valid && req_ready.
- req_ready = !(FIFO full) || (out_valid && out_ready). Simultaneous pop on a full FIFO frees a slot in the same cycle.
- Packing, done combinationally on accept; only the FIFO is registered.
  - R-type (001, 011, 101): [6:3]=req_src2, [2:0]=000. req_imm ignored.
  - I-type (010, 100): [10:7]=req_src1. With mag=|req_imm|: [6]=1 if req_imm<0, else 0; [5:0]=mag[5:0].
  - LOAD (000): same as I-type, but [10:7] is forced to 0000.
  - CLEAR (110): dest kept, [10:0]=0.
  - Zero immediate: always encoded with [6]=0, never as "negative zero".
  - Sign-magnitude range is -IMM_MAX..+IMM_MAX. req_imm=-64 (0xFFC0) is out of range. req_imm=-32768 is out of range; its magnitude must not wrap.
- Rejection: an accepted request with op=111, or an I-type/LOAD with mag>IMM_MAX.
  - The request is consumed; req_ready behaves as for a normal accept.
  - No word is written to the FIFO.
  - err_pulse is asserted the following cycle.
  - err_code is updated; reserved opcode takes precedence.
  - err_count increments and saturates at 255.
- Latency: with the FIFO empty, an accepted valid request appears as out_valid=1 on the cycle after the accept edge.
- Output handshake:
  - out_word is taken from the FIFO head.
  - out_word and out_valid stay stable while out_valid && !out_ready.
  - A word is popped when out_valid && out_ready.
- Ordering: strict FIFO order. Read/write pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit or the level count.
- Simultaneous push and pop: fifo_level is unchanged, and both pointers advance. On an empty FIFO, the new word is presented next cycle; no bypass.
- Rejected request plus a pop in the same cycle: the pop proceeds normally.
- When out_valid=0, out_word holds its last value; the consumer must ignore it.

Test Plan:
- Reset then ADDI dest=3, src1=2, imm=+5 with out_ready=1 -> next cycle out_valid=1, out_word=18'b010_0011_0010_0000101.
- SUBI dest=1, src1=1, imm=-7 (0xFFF9) -> out_word[17:0]=100_0001_0001_1_000111. LOAD with imm=0 -> operand field 0000000 and src1 field 0000.
- ADD dest=4, src1=5, src2=6 -> out_word=001_0100_0101_0110_000; req_imm=0xFFFF has no effect.
- Range errors:
  - LOAD imm=+64 -> err_pulse, err_code=01, err_count=1, no word.
  - imm=-64 -> rejected.
  - imm=+63 -> accepted as operand field 0111111.
  - imm=-32768 -> rejected.
- op=111 -> err_code=10, FIFO level unchanged. Repeat 300 rejects -> err_count=255.
- Buffering and reset:
  - With out_ready=0, push 4 words -> fifo_level=4, req_ready=0.
  - Raise out_ready and keep pushing -> words exit in order, one per cycle, level stays at 4.
  - Assert rst_n=0 mid-stream -> next cycle out_valid=0, level=0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs discrete instruction fields into 18-bit switch-bank words,
// validates them, and buffers the words in a small FIFO drained over valid/ready.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_op/dest/src1/src2 instruction fields
//   req_imm               signed 16-bit immediate (LOAD/ADDI/SUBI)
//   out_valid/out_ready   issue handshake toward the decoder
//   out_word              packed word: [17:15] op, [14:11] dest, [10:7] src1, [6:0] operand
//   err_pulse             one-cycle flag for a rejected request
//   err_code              last error: 01 immediate range, 10 reserved opcode
//   err_count             saturating count of rejected requests
//   fifo_level            number of buffered words
module instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMM_MAX    = 63
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [2:0]                    req_op,
  input  logic [3:0]                    req_dest,
  input  logic [3:0]                    req_src1,
  input  logic [3:0]                    req_src2,
  input  logic [15:0]                   req_imm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [17:0]                   out_word,
  output logic                          err_pulse,
  output logic [1:0]                    err_code,
  output logic [7:0]                    err_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [2:0] {
    OpLoad  = 3'b000,
    OpAdd   = 3'b001,
    OpAddi  = 3'b010,
    OpSub   = 3'b011,
    OpSubi  = 3'b100,
    OpMul   = 3'b101,
    OpClear = 3'b110,
    OpRsvd  = 3'b111
  } op_e;

  logic [17:0]     r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [LvlW-1:0] r_level;
  logic [17:0]     r_hold;
  logic            r_err_pulse;
  logic [1:0]      r_err_code;
  logic [7:0]      r_err_count;

  logic [16:0] w_mag;
  logic        w_range_err;
  logic        w_reject;
  logic [1:0]  w_code;
  logic [17:0] w_word;
  logic        w_empty;
  logic        w_full;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // 17-bit magnitude so that -32768 yields +32768 instead of wrapping to zero.
  assign w_mag       = req_imm[15] ? (17'd0 - {1'b1, req_imm}) : {1'b0, req_imm};
  assign w_range_err = (w_mag > 17'(IMM_MAX));

  always_comb begin
    w_word   = {req_op, req_dest, 11'd0};
    w_reject = 1'b0;
    w_code   = 2'b01;
    case (op_e'(req_op))
      OpLoad: begin
        // A zero immediate never has its sign bit set, so no negative zero.
        w_word[6:0] = {req_imm[15], w_mag[5:0]};
        w_reject    = w_range_err;
      end
      OpAddi, OpSubi: begin
        w_word[10:0] = {req_src1, req_imm[15], w_mag[5:0]};
        w_reject     = w_range_err;
      end
      OpAdd, OpSub, OpMul: begin
        w_word[10:0] = {req_src1, req_src2, 3'b000};
      end
      OpClear: begin
        w_word[10:0] = 11'd0;
      end
      default: begin
        w_reject = 1'b1;
        w_code   = 2'b10;
      end
    endcase
  end

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LvlW'(FIFO_DEPTH));
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  // A pop on a full FIFO frees the slot in the same cycle.
  assign req_ready = !w_full || w_pop;
  assign w_accept  = req_valid && req_ready;
  assign w_push    = w_accept && !w_reject;

  // When empty, present the last popped word rather than a stale slot.
  assign out_word   = w_empty ? r_hold : r_mem[r_rd_ptr];
  assign err_pulse  = r_err_pulse;
  assign err_code   = r_err_code;
  assign err_count  = r_err_count;
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_hold      <= '0;
      r_err_pulse <= 1'b0;
      r_err_code  <= 2'b00;
      r_err_count <= 8'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_hold   <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - 1'b1;
      end
      r_err_pulse <= w_accept && w_reject;
      if (w_accept && w_reject) begin
        r_err_code <= w_code;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int FIFO_DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [3:0]  req_dest;
  logic [3:0]  req_src1;
  logic [3:0]  req_src2;
  logic [15:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_word;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic [2:0]  fifo_level;

  instr_encoder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .IMM_MAX    (63)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_dest   (req_dest),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_imm    (req_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .err_count  (err_count),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: returns {reject, word}.
  function automatic logic [18:0] model_enc(input logic [2:0] op, input logic [3:0] d,
                                            input logic [3:0] s1, input logic [3:0] s2,
                                            input logic [15:0] imm);
    int          v;
    int          m;
    logic        rej;
    logic [17:0] w;
    v   = $signed(imm);
    m   = (v < 0) ? -v : v;
    rej = 1'b0;
    w   = {op, d, 11'd0};
    case (op)
      3'b000: begin
        rej     = (m > 63);
        w[6]    = (v < 0);
        w[5:0]  = m[5:0];
      end
      3'b010, 3'b100: begin
        rej     = (m > 63);
        w[10:7] = s1;
        w[6]    = (v < 0);
        w[5:0]  = m[5:0];
      end
      3'b001, 3'b011, 3'b101: begin
        w[10:7] = s1;
        w[6:3]  = s2;
      end
      3'b110: w[10:0] = 11'd0;
      default: rej = 1'b1;
    endcase
    return {rej, w};
  endfunction

  // Scoreboard state, mirrors what the DUT should show after the last edge.
  logic [17:0] sb_q[$];
  logic [17:0] last_word = '0;
  logic        exp_pulse = 1'b0;
  logic [1:0]  exp_code  = 2'b00;
  logic [7:0]  exp_count = 8'd0;
  logic        m_valid;
  logic        m_ready;
  logic [18:0] m_enc;

  always @(negedge clk) begin
    m_valid = (sb_q.size() != 0);
    m_ready = (sb_q.size() < FIFO_DEPTH) || (m_valid && out_ready);
    check_val("out_valid", 32'(out_valid), 32'(m_valid));
    check_val("fifo_level", 32'(fifo_level), 32'(sb_q.size()));
    check_val("err_pulse", 32'(err_pulse), 32'(exp_pulse));
    check_val("err_code", 32'(err_code), 32'(exp_code));
    check_val("err_count", 32'(err_count), 32'(exp_count));
    if (m_valid) check_val("out_word", 32'(out_word), 32'(sb_q[0]));
    else         check_val("out_word_hold", 32'(out_word), 32'(last_word));
    if (!rst_n) begin
      sb_q.delete();
      last_word = '0;
      exp_pulse = 1'b0;
      exp_code  = 2'b00;
      exp_count = 8'd0;
    end else begin
      check_val("req_ready", 32'(req_ready), 32'(m_ready));
      if (m_valid && out_ready) last_word = sb_q.pop_front();
      exp_pulse = 1'b0;
      if (req_valid && m_ready) begin
        m_enc = model_enc(req_op, req_dest, req_src1, req_src2, req_imm);
        if (m_enc[18]) begin
          exp_pulse = 1'b1;
          exp_code  = (req_op == 3'b111) ? 2'b10 : 2'b01;
          if (exp_count != 8'hFF) exp_count = exp_count + 8'd1;
        end else begin
          sb_q.push_back(m_enc[17:0]);
        end
      end
    end
  end

  logic rand_ready = 1'b0;

  // Drives one request and returns #1 after the edge that accepted it.
  task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1,
                      input logic [3:0] s2, input logic [15:0] imm);
    logic acc;
    int   n;
    acc       = 1'b0;
    n         = 0;
    req_op    = op;
    req_dest  = d;
    req_src1  = s1;
    req_src2  = s2;
    req_imm   = imm;
    req_valid = 1'b1;
    while (!acc && n < 50) begin
      if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_val("send_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  logic [15:0] imm_set[9];
  logic [2:0]  ops;

  initial begin
    imm_set = '{16'h0000, 16'h0001, 16'h003F, 16'h0040, 16'hFFC1, 16'hFFC0,
                16'hFFFF, 16'h8000, 16'h0005};
    rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    req_op = '0; req_dest = '0; req_src1 = '0; req_src2 = '0; req_imm = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_word", 32'(out_word), 32'd0);
    check_val("rst_level", 32'(fifo_level), 32'd0);
    check_val("rst_err_count", 32'(err_count), 32'd0);

    send(3'b010, 4'd3, 4'd2, 4'd0, 16'd5);
    check_val("addi_valid", 32'(out_valid), 32'd1);
    check_val("addi_word", 32'(out_word), 32'(18'b010_0011_0010_0000101));
    send(3'b100, 4'd1, 4'd1, 4'd0, 16'hFFF9);
    check_val("subi_word", 32'(out_word), 32'(18'b100_0001_0001_1_000111));
    send(3'b000, 4'd7, 4'd9, 4'd0, 16'd0);
    check_val("load0_low", 32'(out_word[10:0]), 32'd0);
    send(3'b001, 4'd4, 4'd5, 4'd6, 16'hFFFF);
    check_val("add_word", 32'(out_word), 32'(18'b001_0100_0101_0110_000));

    send(3'b000, 4'd2, 4'd0, 4'd0, 16'd64);
    check_val("load64_pulse", 32'(err_pulse), 32'd1);
    check_val("load64_code", 32'(err_code), 32'd1);
    check_val("load64_count", 32'(err_count), 32'd1);
    check_val("load64_noword", 32'(fifo_level), 32'd0);
    send(3'b010, 4'd2, 4'd1, 4'd0, 16'hFFC0);
    check_val("neg64_count", 32'(err_count), 32'd2);
    send(3'b010, 4'd2, 4'd1, 4'd0, 16'd63);
    check_val("imm63_field", 32'(out_word[6:0]), 32'h3F);
    send(3'b100, 4'd2, 4'd1, 4'd0, 16'h8000);
    check_val("neg32768_count", 32'(err_count), 32'd3);
    send(3'b111, 4'd2, 4'd1, 4'd0, 16'h8000);
    check_val("rsvd_code", 32'(err_code), 32'd2);
    check_val("rsvd_level", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 300; i++) send(3'b111, 4'd0, 4'd0, 4'd0, 16'd0);
    check_val("sat_count", 32'(err_count), 32'd255);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'b001, 4'(i), 4'(i + 1), 4'(i + 2), 16'd0);
    check_val("full_level", 32'(fifo_level), 32'd4);
    check_val("full_ready", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(3'b011, 4'(i + 8), 4'(i), 4'(15 - i), 16'd0);
      check_val("stream_level", 32'(fifo_level), 32'd4);
    end
    req_op = 3'b001; req_valid = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1; req_valid = 1'b0;
    check_val("midrst_valid", 32'(out_valid), 32'd0);
    check_val("midrst_level", 32'(fifo_level), 32'd0);

    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ops = 3'($urandom_range(0, 7));
      send(ops, 4'($urandom), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 4) == 0) ? 16'($urandom) : imm_set[$urandom_range(0, 8)]);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_val("drain_level", 32'(fifo_level), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
